// File: rtl/rv64g_pkg.sv
// ---------------------------------------------------------------------------
// rv64g_pkg
// Shared definitions for the rv64g issue stage.
//   NUM_REGS   : architectural registers tracked by the scoreboard (int + fp)
//   sb_state_e : scoreboard lockout state (normal issue / waiting on a jump)
// ---------------------------------------------------------------------------
package rv64g_pkg;

    localparam int NUM_REGS = 64;

    typedef enum logic {
        SB_IDLE,
        SB_JUMP
    } sb_state_e;

endpackage

// File: rtl/reg_pend_ctr.sv
// ---------------------------------------------------------------------------
// reg_pend_ctr
// Saturating up/down counter of outstanding writes for one register.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_inc            : one write issued to this register this cycle
//   i_dec_cnt        : number of writeback ports completing this register
//   i_clr            : flush, counter returns to zero next cycle
//   o_cnt            : current number of outstanding writes
//   o_full           : counter is at MAX_PEND, no further issue allowed
//   o_underflow      : more writebacks arrived than writes were outstanding
// ---------------------------------------------------------------------------
module reg_pend_ctr
    import rv64g_pkg::*;
#(
    parameter  int MAX_PEND = 3,
    parameter  int NUM_WB   = 2,
    localparam int CW       = $clog2(MAX_PEND + 1),
    localparam int DW       = $clog2(NUM_WB + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_inc,
    input  logic [DW-1:0] i_dec_cnt,
    input  logic          i_clr,
    output logic [CW-1:0] o_cnt,
    output logic          o_full,
    output logic          o_underflow
);

    // Working width wide enough for either operand plus one carry bit.
    localparam int SW = ((CW > DW) ? CW : DW) + 1;

    logic [CW-1:0] r_cnt;
    logic [SW-1:0] w_cur;
    logic [SW-1:0] w_dec;
    logic [SW-1:0] w_dec_eff;
    logic [SW-1:0] w_sum;
    logic [CW-1:0] w_nxt;
    logic          w_under;

    always_comb begin
        w_cur     = SW'(r_cnt);
        w_dec     = SW'(i_dec_cnt);
        // Writebacks beyond the outstanding count are dropped and flagged.
        w_under   = (w_dec > w_cur);
        w_dec_eff = w_under ? w_cur : w_dec;
        // Subtract first so the intermediate never wraps below zero.
        w_sum     = w_cur - w_dec_eff + SW'(i_inc);
        if (w_sum > SW'(MAX_PEND)) begin
            w_sum = SW'(MAX_PEND);
        end
        w_nxt     = i_clr ? '0 : CW'(w_sum);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_nxt;
        end
    end

    assign o_cnt       = r_cnt;
    assign o_full      = (r_cnt == CW'(MAX_PEND));
    assign o_underflow = w_under;

endmodule

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Counter-based register scoreboard for the rv64g issue stage.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   ch_valid_i    : per channel, a valid instruction is presented
//   ch_jump_i     : per channel, the instruction is a jump/branch
//   ch_rd_i       : per channel destination register (0 = untracked)
//   ch_reg_req_i  : per channel bit set of source registers read
//   ch_gnt_o      : per channel, instruction issues this cycle (combinational)
//   wb_valid_i    : per writeback port, a write completes
//   wb_rd_i       : per writeback port destination register
//   jump_done_i   : the outstanding jump has resolved
//   flush_i       : pipeline flush, clears all tracking
//   locks_o       : register busy mask (all-ones while a jump is pending)
//   jump_busy_o   : a jump is pending, issue is blocked
//   err_o         : one-cycle pulse on a writeback with nothing outstanding
// ---------------------------------------------------------------------------
module reg_scoreboard
    import rv64g_pkg::*;
#(
    parameter  int NR       = NUM_REGS,
    parameter  int NUM_CH   = 2,
    parameter  int NUM_WB   = 2,
    parameter  int MAX_PEND = 3,
    localparam int RW       = $clog2(NR),
    localparam int CW       = $clog2(MAX_PEND + 1),
    localparam int DW       = $clog2(NUM_WB + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_CH-1:0]              ch_valid_i,
    input  logic [NUM_CH-1:0]              ch_jump_i,
    input  logic [NUM_CH-1:0][RW-1:0]      ch_rd_i,
    input  logic [NUM_CH-1:0][NR-1:0]      ch_reg_req_i,
    output logic [NUM_CH-1:0]              ch_gnt_o,
    input  logic [NUM_WB-1:0]              wb_valid_i,
    input  logic [NUM_WB-1:0][RW-1:0]      wb_rd_i,
    input  logic                           jump_done_i,
    input  logic                           flush_i,
    output logic [NR-1:0]                  locks_o,
    output logic                           jump_busy_o,
    output logic                           err_o
);

    sb_state_e             r_state;
    sb_state_e             w_state_nxt;
    logic                  r_err;

    logic [NR-1:0][CW-1:0] w_cnt;
    logic [NR-1:0]         w_full;
    logic [NR-1:0]         w_under;
    logic [NR-1:0]         w_nz;
    logic [NUM_CH-1:0]     w_elig;
    logic                  w_blk;

    // Register 0 is hard-wired: never pending, never full, never in error.
    assign w_cnt[0]   = '0;
    assign w_full[0]  = 1'b0;
    assign w_under[0] = 1'b0;

    for (genvar r = 1; r < NR; r++) begin : g_ctr
        logic [NUM_CH-1:0] w_hit_ch;
        logic [DW-1:0]     w_hits;

        always_comb begin
            w_hit_ch = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                w_hit_ch[c] = ch_gnt_o[c] && (ch_rd_i[c] == RW'(r));
            end
            // Several writeback ports may hit the same register; all count.
            w_hits = '0;
            for (int w = 0; w < NUM_WB; w++) begin
                if (wb_valid_i[w] && (wb_rd_i[w] == RW'(r))) begin
                    w_hits = w_hits + DW'(1);
                end
            end
        end

        reg_pend_ctr #(
            .MAX_PEND (MAX_PEND),
            .NUM_WB   (NUM_WB)
        ) u_ctr (
            .i_clk       (clk_i),
            .i_rst       (rst_i),
            .i_inc       (|w_hit_ch),
            .i_dec_cnt   (w_hits),
            .i_clr       (flush_i),
            .o_cnt       (w_cnt[r]),
            .o_full      (w_full[r]),
            .o_underflow (w_under[r])
        );
    end

    always_comb begin
        for (int r = 0; r < NR; r++) begin
            w_nz[r] = (w_cnt[r] != '0);
        end
    end

    // Lock mask is a pure function of flopped state (counters and FSM), so a
    // same-cycle writeback never unblocks a source until the next cycle.
    assign locks_o     = (r_state == SB_JUMP) ? '1 : w_nz;
    assign jump_busy_o = (r_state == SB_JUMP);
    assign err_o       = r_err;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_elig[i] = ch_valid_i[i] && (r_state == SB_IDLE) && !rst_i && !flush_i
                        && ((ch_reg_req_i[i] & locks_o) == '0)
                        && ((ch_rd_i[i] == '0) || !w_full[ch_rd_i[i]]);
        end
    end

    // Fixed priority: a granted higher channel blocks a lower one if it is a
    // jump, writes one of its sources, or writes the same destination.
    always_comb begin
        ch_gnt_o = '0;
        w_blk    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_blk = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (ch_gnt_o[j]) begin
                    if (ch_jump_i[j]) begin
                        w_blk = 1'b1;
                    end
                    if ((ch_rd_i[j] != '0) &&
                        (ch_reg_req_i[i][ch_rd_i[j]] || (ch_rd_i[j] == ch_rd_i[i]))) begin
                        w_blk = 1'b1;
                    end
                end
            end
            ch_gnt_o[i] = w_elig[i] && !w_blk;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SB_IDLE: if ((ch_gnt_o & ch_jump_i) != '0) w_state_nxt = SB_JUMP;
            SB_JUMP: if (jump_done_i)                  w_state_nxt = SB_IDLE;
            default:                                   w_state_nxt = SB_IDLE;
        endcase
        if (flush_i) begin
            w_state_nxt = SB_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= SB_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Writebacks in a flush cycle are discarded silently.
            r_err   <= !flush_i && (w_under != '0);
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
    import rv64g_pkg::*;

    localparam int NR       = NUM_REGS;
    localparam int NUM_CH   = 2;
    localparam int NUM_WB   = 2;
    localparam int MAX_PEND = 3;
    localparam int RW       = $clog2(NR);

    logic                      clk;
    logic                      rst;
    logic [NUM_CH-1:0]         ch_valid;
    logic [NUM_CH-1:0]         ch_jump;
    logic [NUM_CH-1:0][RW-1:0] ch_rd;
    logic [NUM_CH-1:0][NR-1:0] ch_req;
    logic [NUM_CH-1:0]         gnt;
    logic [NUM_WB-1:0]         wb_valid;
    logic [NUM_WB-1:0][RW-1:0] wb_rd;
    logic                      jump_done;
    logic                      flush;
    logic [NR-1:0]             locks;
    logic                      jump_busy;
    logic                      err;

    int                        n_tests = 0;
    int                        n_fail  = 0;
    logic [NUM_CH-1:0]         last_gnt;

    // Reference model: outstanding write count per register, jump flag, error flag.
    int m_pend [NR];
    bit m_jump = 1'b0;
    bit m_err  = 1'b0;

    reg_scoreboard #(
        .NR       (NR),
        .NUM_CH   (NUM_CH),
        .NUM_WB   (NUM_WB),
        .MAX_PEND (MAX_PEND)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ch_valid_i   (ch_valid),
        .ch_jump_i    (ch_jump),
        .ch_rd_i      (ch_rd),
        .ch_reg_req_i (ch_req),
        .ch_gnt_o     (gnt),
        .wb_valid_i   (wb_valid),
        .wb_rd_i      (wb_rd),
        .jump_done_i  (jump_done),
        .flush_i      (flush),
        .locks_o      (locks),
        .jump_busy_o  (jump_busy),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [NR-1:0] obs, input logic [NR-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR-1:0] model_locks();
        logic [NR-1:0] l;
        l = '0;
        if (m_jump) begin
            l = '1;
        end else begin
            for (int r = 0; r < NR; r++) l[r] = (m_pend[r] != 0);
        end
        return l;
    endfunction

    // Walk channels in priority order; each issued instruction claims its
    // destination for the rest of the cycle, and a jump ends issue outright.
    function automatic logic [NUM_CH-1:0] model_gnt();
        logic [NUM_CH-1:0] g;
        logic [NR-1:0]     claimed;
        logic [NR-1:0]     lk;
        bit                stop;
        bit                ok;
        int                d;
        g       = '0;
        claimed = '0;
        stop    = 1'b0;
        lk      = model_locks();
        for (int i = 0; i < NUM_CH; i++) begin
            d  = int'(ch_rd[i]);
            ok = ch_valid[i] && !m_jump && !rst && !flush && !stop;
            if ((ch_req[i] & lk) != '0)      ok = 1'b0;
            if ((ch_req[i] & claimed) != '0) ok = 1'b0;
            if (d != 0 && m_pend[d] >= MAX_PEND) ok = 1'b0;
            if (d != 0 && claimed[d])        ok = 1'b0;
            if (ok) begin
                g[i] = 1'b1;
                if (d != 0) claimed[d] = 1'b1;
                if (ch_jump[i]) stop = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic model_step(input logic [NUM_CH-1:0] g);
        int hits;
        int inc;
        if (rst || flush) begin
            for (int r = 0; r < NR; r++) m_pend[r] = 0;
            m_jump = 1'b0;
            m_err  = 1'b0;
        end else begin
            m_err = 1'b0;
            for (int r = 1; r < NR; r++) begin
                hits = 0;
                inc  = 0;
                for (int w = 0; w < NUM_WB; w++)
                    if (wb_valid[w] && int'(wb_rd[w]) == r) hits++;
                for (int c = 0; c < NUM_CH; c++)
                    if (g[c] && int'(ch_rd[c]) == r) inc = 1;
                if (hits > m_pend[r]) begin
                    m_err = 1'b1;
                    hits  = m_pend[r];
                end
                m_pend[r] = m_pend[r] - hits + inc;
            end
            if (m_jump) begin
                if (jump_done) m_jump = 1'b0;
            end else if ((g & ch_jump) != '0) begin
                m_jump = 1'b1;
            end
        end
    endtask

    // One clock cycle: settle inputs, compare every output with the model,
    // advance the model, then move to just after the rising edge.
    task automatic tick();
        logic [NUM_CH-1:0] eg;
        #1;
        eg       = model_gnt();
        last_gnt = gnt;
        chk("gnt",       NR'(gnt),       NR'(eg));
        chk("locks",     locks,          model_locks());
        chk("jump_busy", NR'(jump_busy), NR'(m_jump));
        chk("err",       NR'(err),       NR'(m_err));
        model_step(eg);
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        ch_valid  = '0;
        ch_jump   = '0;
        ch_rd     = '0;
        ch_req    = '0;
        wb_valid  = '0;
        wb_rd     = '0;
        jump_done = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic do_rst();
        clr_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < NR; r++) m_pend[r] = 0;

        // Reset with every input active.
        rst       = 1'b1;
        ch_valid  = '1;
        ch_jump   = '1;
        ch_rd[0]  = RW'(3);
        ch_rd[1]  = RW'(4);
        ch_req    = '0;
        wb_valid  = '1;
        wb_rd[0]  = RW'(3);
        wb_rd[1]  = RW'(4);
        jump_done = 1'b1;
        flush     = 1'b1;
        #1;
        chk("rst_gnt_first", NR'(gnt), '0);
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        clr_in();
        tick();
        chk("rst_locks", locks, '0);
        chk("rst_busy",  NR'(jump_busy), '0);
        chk("rst_err",   NR'(err), '0);

        // Intra-cycle RAW, then release through writeback.
        ch_valid     = 2'b11;
        ch_rd[0]     = RW'(5);
        ch_rd[1]     = RW'(6);
        ch_req[1][5] = 1'b1;
        tick();
        chk("raw_gnt", NR'(last_gnt), NR'(2'b01));
        chk("raw_lock5", NR'(locks[5]), NR'(1));
        ch_valid = 2'b10;
        wb_valid = 2'b01;
        wb_rd[0] = RW'(5);
        tick();
        chk("raw_wb_same_cycle", NR'(last_gnt), NR'(2'b00));
        chk("raw_unlock5", NR'(locks[5]), NR'(0));
        wb_valid = '0;
        tick();
        chk("raw_gnt_after_wb", NR'(last_gnt), NR'(2'b10));

        // Saturation on rd 7.
        do_rst();
        ch_valid = 2'b01;
        ch_rd[0] = RW'(7);
        repeat (3) tick();
        tick();
        chk("sat_stall", NR'(last_gnt), NR'(2'b00));
        wb_valid = 2'b01;
        wb_rd[0] = RW'(7);
        tick();
        chk("sat_wb_same_cycle", NR'(last_gnt), NR'(2'b00));
        wb_valid = '0;
        tick();
        chk("sat_resume", NR'(last_gnt), NR'(2'b01));
        ch_valid = '0;
        wb_valid = 2'b01;
        tick();
        ch_valid = 2'b01;
        tick();
        chk("sat_net_gnt", NR'(last_gnt), NR'(2'b01));
        wb_valid = '0;
        tick();
        chk("sat_net_fill", NR'(last_gnt), NR'(2'b01));
        tick();
        chk("sat_net_stall", NR'(last_gnt), NR'(2'b00));

        // Jump lockout.
        do_rst();
        ch_valid = 2'b11;
        ch_jump  = 2'b01;
        ch_rd[0] = RW'(1);
        ch_rd[1] = RW'(2);
        tick();
        chk("jmp_gnt", NR'(last_gnt), NR'(2'b01));
        chk("jmp_busy", NR'(jump_busy), NR'(1));
        chk("jmp_locks", locks, '1);
        ch_jump = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("jmp_block", NR'(last_gnt), NR'(2'b00));
        end
        jump_done = 1'b1;
        tick();
        jump_done = 1'b0;
        chk("jmp_done_busy", NR'(jump_busy), NR'(0));
        chk("jmp_done_locks", locks, NR'(2));

        // rd 0, underflow, double writeback.
        do_rst();
        ch_valid = 2'b01;
        ch_rd[0] = RW'(0);
        tick();
        chk("rd0_gnt", NR'(last_gnt), NR'(2'b01));
        chk("rd0_locks", locks, '0);
        ch_valid = '0;
        wb_valid = 2'b01;
        wb_rd[0] = RW'(9);
        tick();
        chk("uf_err", NR'(err), NR'(1));
        wb_valid = '0;
        tick();
        chk("uf_err_pulse", NR'(err), NR'(0));
        ch_valid = 2'b01;
        ch_rd[0] = RW'(9);
        repeat (2) tick();
        ch_valid = '0;
        wb_valid = 2'b11;
        wb_rd[0] = RW'(9);
        wb_rd[1] = RW'(9);
        tick();
        chk("dwb_lock9", NR'(locks[9]), NR'(0));
        chk("dwb_err", NR'(err), NR'(0));

        // Flush mid-jump.
        do_rst();
        ch_valid = 2'b01;
        ch_rd[0] = RW'(3);
        repeat (2) tick();
        ch_jump  = 2'b01;
        ch_rd[0] = RW'(0);
        tick();
        ch_jump = '0;
        chk("fl_busy_before", NR'(jump_busy), NR'(1));
        flush    = 1'b1;
        ch_rd[0] = RW'(4);
        wb_valid = 2'b01;
        wb_rd[0] = RW'(9);
        tick();
        chk("fl_gnt", NR'(last_gnt), NR'(2'b00));
        chk("fl_locks", locks, '0);
        chk("fl_busy", NR'(jump_busy), NR'(0));
        chk("fl_err", NR'(err), NR'(0));

        // Randomised traffic against the model.
        do_rst();
        for (int n = 0; n < 800; n++) begin
            clr_in();
            rst = ($urandom_range(0, 63) == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                ch_valid[c] = $urandom_range(0, 3) != 0;
                ch_jump[c]  = $urandom_range(0, 7) == 0;
                ch_rd[c]    = RW'($urandom_range(0, 10));
                if ($urandom_range(0, 1) == 1) ch_req[c][$urandom_range(1, 10)] = 1'b1;
                if ($urandom_range(0, 3) == 0) ch_req[c][$urandom_range(1, 10)] = 1'b1;
            end
            for (int w = 0; w < NUM_WB; w++) begin
                wb_valid[w] = $urandom_range(0, 2) == 0;
                wb_rd[w]    = RW'($urandom_range(1, 10));
            end
            jump_done = $urandom_range(0, 3) == 0;
            flush     = $urandom_range(0, 39) == 0;
            tick();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
